// File: rtl/axi_mem_responder_pkg.sv
// Shared encodings for axi_mem_responder: burst types, response codes and FSM states.
package axi_mem_responder_pkg;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WResp
  } w_state_e;

  typedef enum logic [0:0] {
    RIdle,
    RBurst
  } r_state_e;

  // Only FIXED holds the index; WRAP and reserved encodings step like INCR.
  function automatic logic burst_is_fixed(logic [1:0] burst);
    return burst == BurstFixed;
  endfunction

endpackage

// File: rtl/axi_mem_responder_iob_2p_ram.sv
// Simple dual-port RAM: one byte-enabled write port, one read port, 1-cycle read-first latency.
module iob_2p_ram #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 14
) (
  input  logic                clk_i,
  input  logic                w_en_i,
  input  logic [DATA_W/8-1:0] w_strb_i,
  input  logic [ADDR_W-1:0]   w_addr_i,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic                r_en_i,
  input  logic [ADDR_W-1:0]   r_addr_i,
  output logic [DATA_W-1:0]   r_data_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] r_data_q;

  always_ff @(posedge clk_i) begin
    if (w_en_i) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (w_strb_i[i]) begin
          mem[w_addr_i][i*8 +: 8] <= w_data_i[i*8 +: 8];
        end
      end
    end
    // Same-edge read of a word being written returns the pre-write contents.
    if (r_en_i) begin
      r_data_q <= mem[r_addr_i];
    end
  end

  assign r_data_o = r_data_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave answering the DDR master port from an on-chip dual-port RAM.
// Define AXI_MEM_WLAST_CHECK_EN to flag wlast/len mismatches with SLVERR on B.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned MEM_ADDR_W = 14
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic [2:0]          s_axi_awprot,
  input  logic [3:0]          s_axi_awqos,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,

  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,

  output logic                s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,

  input  logic                s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic [3:0]          s_axi_arqos,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,

  output logic                s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int unsigned OffW = $clog2(DATA_W / 8);
  localparam logic [MEM_ADDR_W-1:0] IdxOne = 1;

  logic [MEM_ADDR_W-1:0] aw_idx, ar_idx;
  assign aw_idx = s_axi_awaddr[MEM_ADDR_W+OffW-1:OffW];
  assign ar_idx = s_axi_araddr[MEM_ADDR_W+OffW-1:OffW];

  // ---------------------------------------------------------------- write side
  w_state_e              w_state_q;
  logic                  awready_q, wready_q, bvalid_q, bid_q;
  logic [1:0]            bresp_q;
  logic [MEM_ADDR_W-1:0] widx_q;
  logic [7:0]            wlen_q, wcnt_q;
  logic                  wfixed_q;
  logic                  w_hs, w_last_beat;
  logic [1:0]            w_resp;

  assign w_hs        = s_axi_wvalid & wready_q;
  assign w_last_beat = (wcnt_q == wlen_q);

`ifdef AXI_MEM_WLAST_CHECK_EN
  logic werr_q;
  logic wlast_bad;
  assign wlast_bad = (s_axi_wlast != w_last_beat);
  assign w_resp    = (werr_q | wlast_bad) ? RespSlverr : RespOkay;
`else
  assign w_resp    = RespOkay;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= WIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= 1'b0;
      bresp_q   <= RespOkay;
      widx_q    <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wfixed_q  <= 1'b0;
`ifdef AXI_MEM_WLAST_CHECK_EN
      werr_q    <= 1'b0;
`endif
    end else begin
      unique case (w_state_q)
        WIdle: begin
          awready_q <= 1'b1;
          if (s_axi_awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= s_axi_awid;
            widx_q    <= aw_idx;
            wlen_q    <= s_axi_awlen;
            wcnt_q    <= '0;
            wfixed_q  <= burst_is_fixed(s_axi_awburst);
`ifdef AXI_MEM_WLAST_CHECK_EN
            werr_q    <= 1'b0;
`endif
            w_state_q <= WData;
          end
        end
        WData: begin
          if (w_hs) begin
            if (!wfixed_q) widx_q <= widx_q + IdxOne;
            wcnt_q <= wcnt_q + 8'd1;
`ifdef AXI_MEM_WLAST_CHECK_EN
            werr_q <= werr_q | wlast_bad;
`endif
            if (w_last_beat) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= w_resp;
              w_state_q <= WResp;
            end
          end
        end
        WResp: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;

  // ----------------------------------------------------------------- read side
  r_state_e              r_state_q;
  logic                  arready_q, rid_q;
  logic [MEM_ADDR_W-1:0] ridx_q;
  logic [7:0]            rlen_q;
  logic                  rfixed_q;
  logic [8:0]            rissue_q;
  logic                  infl_q, infl_last_q;
  logic                  rvalid_q, rlast_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  sk_valid_q, sk_last_q;
  logic [DATA_W-1:0]     sk_data_q;
  logic [DATA_W-1:0]     ram_rdata;
  logic                  r_pop, rd_issue, issue_last;
  logic [1:0]            r_level;

  assign r_pop      = rvalid_q & s_axi_rready;
  // Occupancy after this cycle's pop plus the word already in the RAM pipeline.
  assign r_level    = 2'(rvalid_q) + 2'(sk_valid_q) + 2'(infl_q) - 2'(r_pop);
  assign issue_last = (rissue_q == {1'b0, rlen_q});
  assign rd_issue   = (r_state_q == RBurst) && (rissue_q <= {1'b0, rlen_q})
                      && (r_level < 2'd2);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q   <= RIdle;
      arready_q   <= 1'b0;
      rid_q       <= 1'b0;
      ridx_q      <= '0;
      rlen_q      <= '0;
      rfixed_q    <= 1'b0;
      rissue_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= '0;
      sk_valid_q  <= 1'b0;
      sk_last_q   <= 1'b0;
      sk_data_q   <= '0;
    end else begin
      infl_q      <= rd_issue;
      infl_last_q <= rd_issue & issue_last;
      if (rd_issue) begin
        rissue_q <= rissue_q + 9'd1;
        if (!rfixed_q) ridx_q <= ridx_q + IdxOne;
      end

      // Two-entry FIFO: rdata_q is the head, sk_* the second slot.
      if (r_pop) begin
        if (sk_valid_q) begin
          rdata_q    <= sk_data_q;
          rlast_q    <= sk_last_q;
          sk_valid_q <= infl_q;
          if (infl_q) begin
            sk_data_q <= ram_rdata;
            sk_last_q <= infl_last_q;
          end
        end else if (infl_q) begin
          rdata_q <= ram_rdata;
          rlast_q <= infl_last_q;
        end else begin
          rvalid_q <= 1'b0;
          rlast_q  <= 1'b0;
        end
      end else if (infl_q) begin
        if (!rvalid_q) begin
          rvalid_q <= 1'b1;
          rdata_q  <= ram_rdata;
          rlast_q  <= infl_last_q;
        end else begin
          sk_valid_q <= 1'b1;
          sk_data_q  <= ram_rdata;
          sk_last_q  <= infl_last_q;
        end
      end

      unique case (r_state_q)
        RIdle: begin
          arready_q <= 1'b1;
          if (s_axi_arvalid && arready_q) begin
            arready_q <= 1'b0;
            rid_q     <= s_axi_arid;
            ridx_q    <= ar_idx;
            rlen_q    <= s_axi_arlen;
            rfixed_q  <= burst_is_fixed(s_axi_arburst);
            rissue_q  <= '0;
            r_state_q <= RBurst;
          end
        end
        RBurst: begin
          if (r_pop && rlast_q) begin
            arready_q <= 1'b1;
            r_state_q <= RIdle;
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RespOkay;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rvalid  = rvalid_q;

  iob_2p_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk_i    (clk),
    .w_en_i   (w_hs),
    .w_strb_i (s_axi_wstrb),
    .w_addr_i (widx_q),
    .w_data_i (s_axi_wdata),
    .r_en_i   (rd_issue),
    .r_addr_i (ridx_q),
    .r_data_o (ram_rdata)
  );

  logic unused_inputs;
`ifdef AXI_MEM_WLAST_CHECK_EN
  assign unused_inputs = ^{s_axi_awaddr, s_axi_awsize, s_axi_awlock, s_axi_awcache,
                           s_axi_awprot, s_axi_awqos, s_axi_araddr, s_axi_arsize,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};
`else
  assign unused_inputs = ^{s_axi_awaddr, s_axi_awsize, s_axi_awlock, s_axi_awcache,
                           s_axi_awprot, s_axi_awqos, s_axi_araddr, s_axi_arsize,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                           s_axi_wlast};
`endif

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: directed cases plus randomized bursts vs a word model.
module tb_axi_mem_responder;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 256;
  localparam int MEM_ADDR_W = 14;
  localparam int OFF = 5;
  localparam int DEPTH = 1 << MEM_ADDR_W;
`ifdef AXI_MEM_WLAST_CHECK_EN
  localparam logic [1:0] BadLastResp = 2'b10;
`else
  localparam logic [1:0] BadLastResp = 2'b00;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic              awid, awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [1:0]        awburst;
  logic [DATA_W-1:0] wdata;
  logic [31:0]       wstrb;
  logic              wlast, wvalid, wready;
  logic              bid, bvalid, bready;
  logic [1:0]        bresp;
  logic              arid, arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [1:0]        arburst;
  logic              rid, rlast, rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  axi_mem_responder #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_ADDR_W (MEM_ADDR_W)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .s_axi_awid    (awid),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awsize  (3'd5),
    .s_axi_awburst (awburst),
    .s_axi_awlock  (1'b0),
    .s_axi_awcache (4'd0),
    .s_axi_awprot  (3'd0),
    .s_axi_awqos   (4'd0),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_arid    (arid),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (3'd5),
    .s_axi_arburst (arburst),
    .s_axi_arlock  (1'b0),
    .s_axi_arcache (4'd0),
    .s_axi_arprot  (3'd0),
    .s_axi_arqos   (4'd0),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rid     (rid),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              known;
    logic              last;
    logic              id;
  } rexp_t;

  typedef struct {
    logic       id;
    logic [1:0] resp;
  } bexp_t;

  logic [DATA_W-1:0] mem_m [int];
  rexp_t rq[$];
  bexp_t bq[$];
  logic [DATA_W-1:0] wbuf [16];
  logic [31:0]       sbuf [16];

  int n_assert = 0;
  int n_fail = 0;
  int n_rbeats = 0;
  int rmode = 0;
  logic [DATA_W-1:0] last_rdata = '0;
  logic              last_rlast = 1'b0;
  logic [1:0]        last_bresp = 2'b11;

  function automatic void chk(string nm, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic int word_of(logic [ADDR_W-1:0] a);
    return int'((a >> OFF) % DEPTH);
  endfunction

  // Compare process: checks every presented R beat and B response against the model queues.
  always @(negedge clk) begin
    if (resetn) begin
      if (rvalid) begin
        chk("r_expected_pending", DATA_W'(rq.size() != 0), DATA_W'(1));
        if (rq.size() != 0) begin
          if (rq[0].known) chk("rdata", rdata, rq[0].data);
          chk("rlast", DATA_W'(rlast), DATA_W'(rq[0].last));
          chk("rid", DATA_W'(rid), DATA_W'(rq[0].id));
          chk("rresp", DATA_W'(rresp), '0);
          if (rready) begin
            last_rdata = rdata;
            last_rlast = rlast;
            n_rbeats++;
            void'(rq.pop_front());
          end
        end
      end
      if (bvalid) begin
        chk("b_expected_pending", DATA_W'(bq.size() != 0), DATA_W'(1));
        if (bq.size() != 0) begin
          chk("bid", DATA_W'(bid), DATA_W'(bq[0].id));
          chk("bresp", DATA_W'(bresp), DATA_W'(bq[0].resp));
          if (bready) begin
            last_bresp = bresp;
            void'(bq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: rready = 1'b1;
        1: rready = 1'($urandom_range(0, 1));
        default: rready = ~rready;
      endcase
    end
  end

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic id, input int bad_last);
    int t;
    int idx;
    logic mism;
    bexp_t be;
    mism = 1'b0;
    awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!awready && t < 200) begin @(negedge clk); t++; end
    chk("aw_ready_wait", DATA_W'(t < 200), DATA_W'(1));
    @(posedge clk); #1;
    awvalid = 1'b0;
    idx = word_of(addr);
    for (int b = 0; b <= int'(len); b++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      wdata = wbuf[b]; wstrb = sbuf[b];
      wlast = (bad_last >= 0) ? (b == bad_last) : (b == int'(len));
      if (wlast != (b == int'(len))) mism = 1'b1;
      wvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!wready && t < 200) begin @(negedge clk); t++; end
      chk("w_ready_wait", DATA_W'(t < 200), DATA_W'(1));
      @(posedge clk);
      if (mem_m.exists(idx)) begin
        for (int k = 0; k < 32; k++)
          if (sbuf[b][k]) mem_m[idx][k*8 +: 8] = wbuf[b][k*8 +: 8];
      end else if (sbuf[b] == 32'hFFFF_FFFF) begin
        mem_m[idx] = wbuf[b];
      end
      #1;
      wvalid = 1'b0; wlast = 1'b0;
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
    be.id = id;
    be.resp = mism ? BadLastResp : 2'b00;
    bq.push_back(be);
    t = 0;
    while (bq.size() != 0 && t < 200) begin
      bready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      t++;
    end
    bready = 1'b0;
    chk("b_done_wait", DATA_W'(t < 200), DATA_W'(1));
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic id, input bit lat);
    int t;
    int idx;
    rexp_t e;
    idx = word_of(addr);
    for (int k = 0; k <= int'(len); k++) begin
      e.known = mem_m.exists(idx);
      e.data = e.known ? mem_m[idx] : '0;
      e.last = (k == int'(len));
      e.id = id;
      rq.push_back(e);
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
    araddr = addr; arlen = len; arburst = burst; arid = id; arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!arready && t < 200) begin @(negedge clk); t++; end
    chk("ar_ready_wait", DATA_W'(t < 200), DATA_W'(1));
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (lat) begin
      @(negedge clk); chk("lat_edge0_rvalid", DATA_W'(rvalid), DATA_W'(0));
      @(negedge clk); chk("lat_edge1_rvalid", DATA_W'(rvalid), DATA_W'(0));
      @(negedge clk); chk("lat_edge2_rvalid", DATA_W'(rvalid), DATA_W'(1));
      @(posedge clk); #1;
    end
    t = 0;
    while (rq.size() != 0 && t < 500) begin @(posedge clk); #1; t++; end
    chk("r_done_wait", DATA_W'(t < 500), DATA_W'(1));
  endtask

  task automatic fill(input int n, input int base);
    for (int b = 0; b < n; b++) begin
      wbuf[b] = DATA_W'(base + b);
      sbuf[b] = 32'hFFFF_FFFF;
    end
  endtask

  int rb0;
  int t;
  logic [ADDR_W-1:0] a;
  logic [7:0] ln;

  initial begin
    awid = 0; awaddr = '0; awlen = '0; awburst = 2'b01; awvalid = 0;
    wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0;
    arid = 0; araddr = '0; arlen = '0; arburst = 2'b01; arvalid = 0;

    // Reset state, and ready rises on the first edge after release.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl_outputs", DATA_W'({awready, wready, bvalid, bid, bresp, arready, rvalid,
                                        rlast, rid, rresp}), '0);
    chk("reset_rdata", rdata, '0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("awready_before_edge", DATA_W'(awready), DATA_W'(0));
    @(posedge clk); #1;
    chk("awready_after_edge", DATA_W'(awready), DATA_W'(1));
    chk("arready_after_edge", DATA_W'(arready), DATA_W'(1));

    // Single beat write then read with latency check.
    rmode = 0;
    wbuf[0] = {32{8'hA5}}; sbuf[0] = 32'hFFFF_FFFF;
    do_write(30'h40, 8'd0, 2'b01, 1'b1, -1);
    chk("single_bresp", DATA_W'(last_bresp), DATA_W'(0));
    do_read(30'h40, 8'd0, 2'b01, 1'b0, 1'b1);
    chk("single_rdata", last_rdata, {32{8'hA5}});
    chk("single_rlast", DATA_W'(last_rlast), DATA_W'(1));

    // INCR burst read back with rready toggling.
    fill(8, 0);
    do_write(30'h0, 8'd7, 2'b01, 1'b0, -1);
    rmode = 2;
    rb0 = n_rbeats;
    do_read(30'h0, 8'd7, 2'b01, 1'b1, 1'b0);
    chk("incr_beat_count", DATA_W'(n_rbeats - rb0), DATA_W'(8));
    chk("incr_last_data", last_rdata, DATA_W'(7));
    rmode = 0;

    // FIXED burst: every beat hits the same word, the last one wins.
    fill(4, 1);
    do_write(30'h100, 8'd3, 2'b00, 1'b0, -1);
    do_read(30'h100, 8'd0, 2'b01, 1'b0, 1'b0);
    chk("fixed_rdata", last_rdata, DATA_W'(4));

    // Byte strobes.
    wbuf[0] = '1; sbuf[0] = 32'hFFFF_FFFF;
    do_write(30'h200, 8'd0, 2'b01, 1'b0, -1);
    wbuf[0] = '0; sbuf[0] = 32'h1;
    do_write(30'h200, 8'd0, 2'b01, 1'b0, -1);
    do_read(30'h200, 8'd0, 2'b01, 1'b0, 1'b0);
    chk("strobe_rdata", last_rdata, {{31{8'hFF}}, 8'h00});

    // Index wrap within a burst, and aliasing of upper address bits.
    wbuf[0] = DATA_W'(32'hAAAA_0001); wbuf[1] = DATA_W'(32'hBBBB_0002);
    sbuf[0] = 32'hFFFF_FFFF; sbuf[1] = 32'hFFFF_FFFF;
    do_write(ADDR_W'((DEPTH - 1) << OFF), 8'd1, 2'b01, 1'b0, -1);
    do_read(30'h0, 8'd0, 2'b01, 1'b0, 1'b0);
    chk("wrap_word0", last_rdata, DATA_W'(32'hBBBB_0002));
    do_read(ADDR_W'(1) << (MEM_ADDR_W + OFF), 8'd0, 2'b01, 1'b1, 1'b0);
    chk("alias_word0", last_rdata, DATA_W'(32'hBBBB_0002));

    // Early wlast: flagged only when the check is built in; burst still ends on len.
    fill(4, 16'h300);
    do_write(30'h300, 8'd3, 2'b01, 1'b1, 1);
    chk("wlast_bresp", DATA_W'(last_bresp), DATA_W'(BadLastResp));
    do_read(30'h300, 8'd3, 2'b01, 1'b0, 1'b0);
    chk("wlast_burst_data", last_rdata, DATA_W'(16'h303));

    // Randomized bursts around low words and the top of the RAM.
    for (int it = 0; it < 30; it++) begin
      rmode = $urandom_range(0, 2);
      a = ADDR_W'($urandom);
      a[MEM_ADDR_W+OFF-1 -: MEM_ADDR_W] = ($urandom_range(0, 1) == 1) ?
          MEM_ADDR_W'($urandom_range(0, 23)) : MEM_ADDR_W'(DEPTH - 12 + $urandom_range(0, 11));
      ln = 8'($urandom_range(0, 9));
      for (int b = 0; b < 16; b++) begin
        for (int j = 0; j < 8; j++) wbuf[b][32*j +: 32] = $urandom;
        sbuf[b] = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
      end
      do_write(a, ln, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1);
      if ($urandom_range(0, 1) == 1) a = ADDR_W'(a + ADDR_W'($urandom_range(0, 3) << OFF));
      do_read(a, 8'($urandom_range(0, 9)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset while beat 2 of an 8-beat read is presented; RAM must keep its contents.
    rmode = 0;
    fill(8, 16'h400);
    do_write(30'h400, 8'd7, 2'b01, 1'b0, -1);
    rb0 = n_rbeats;
    fork
      do_read(30'h400, 8'd7, 2'b01, 1'b1, 1'b0);
      begin
        t = 0;
        while (n_rbeats < rb0 + 2 && t < 200) begin @(negedge clk); t++; end
        chk("reset_trigger_wait", DATA_W'(t < 200), DATA_W'(1));
        @(posedge clk); #2;
        resetn = 1'b0;
        rq.delete();
        #1;
        chk("midreset_ctrl_outputs", DATA_W'({awready, wready, bvalid, bid, bresp, arready,
                                              rvalid, rlast, rid, rresp}), '0);
        chk("midreset_rdata", rdata, '0);
      end
    join
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_arready", DATA_W'(arready), DATA_W'(1));
    do_read(30'h400, 8'd7, 2'b01, 1'b0, 1'b0);
    chk("post_reset_data", last_rdata, DATA_W'(16'h407));

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
